// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  // Pointer width for a power-of-2 depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counters must also represent the value 'depth' itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO holding {pc, instr}; head is visible the cycle after its push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/gnt/rvalid handling, credit-limited prefetch and redirect flush.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           BUS_WIDTH  = 32,
  parameter int unsigned           PC_WIDTH   = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [BUS_WIDTH-1:0]  imem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  instr_valid,
  output logic [BUS_WIDTH-1:0]  instr,
  output logic [PC_WIDTH-1:0]   instr_pc,
  input  logic                  next_instr
);

  localparam int unsigned        CW      = cnt_width(FIFO_DEPTH);
  localparam int unsigned        EW      = PC_WIDTH + BUS_WIDTH;
  localparam logic [CW:0]        CREDITS = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(INSTR_BYTES - 1);

  fetch_state_e         state;
  logic [PC_WIDTH-1:0]  fetch_pc;
  logic [PC_WIDTH-1:0]  resp_pc;
  logic [PC_WIDTH-1:0]  redirect_target;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        outstanding_nxt;
  logic [CW:0]          credit_used;
  logic                 granted;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [EW-1:0]        fifo_head;

  // Buffered words plus in-flight requests never exceed the FIFO depth,
  // so every response that arrives is guaranteed a slot.
  assign credit_used     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req        = (state == S_RUN) && (credit_used < CREDITS);
  assign imem_addr       = fetch_pc;
  assign granted         = imem_req && imem_gnt;
  assign redirect_target = redirect_pc & ALIGN_MASK;

  // Same expression serves normal tracking and the stale count on redirect:
  // a same-cycle grant is still in flight, a same-cycle response is consumed.
  assign outstanding_nxt = outstanding + CW'(granted) - CW'(imem_rvalid);

  assign fifo_push = (state == S_RUN) && imem_rvalid && !redirect_valid;
  assign fifo_pop  = next_instr && !fifo_empty && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_target;
      resp_pc     <= redirect_target;
      outstanding <= outstanding_nxt;
      state       <= (outstanding_nxt != '0) ? S_FLUSH : S_RUN;
    end else begin
      if (granted)   fetch_pc <= fetch_pc + PC_STEP;
      if (fifo_push) resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding_nxt;
      case (state)
        S_RESET: state <= S_RUN;
        S_RUN:   state <= S_RUN;
        S_FLUSH: if (outstanding_nxt == '0) state <= S_RUN;
        default: state <= S_RESET;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({resp_pc, imem_rdata}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : fifo_head[BUS_WIDTH-1:0];
  assign instr_pc    = fifo_empty ? '0 : fifo_head[EW-1:BUS_WIDTH];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && fifo_full));

  a_outstanding_cap: assert property (@(posedge clk) disable iff (rst)
    outstanding <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order imem model.
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        next_instr = 1'b0;

  int total = 0;
  int bad   = 0;
  int lat   = 1;
  int cyc   = 0;

  logic [31:0] q_addr [$];
  int          q_due  [$];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .BUS_WIDTH  (32),
    .PC_WIDTH   (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .next_instr     (next_instr)
  );

  // imem: responds in order, 'lat' cycles after the grant; rdata = addr ^ KEY.
  always @(posedge clk) begin
    bit          g, r, rs;
    logic [31:0] a;
    g  = imem_req && imem_gnt;
    r  = imem_rvalid;
    a  = imem_addr;
    rs = rst;
    #1;
    cyc++;
    if (rs) begin
      q_addr.delete();
      q_due.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (r && q_addr.size() > 0) begin
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      if (g) begin
        q_addr.push_back(a);
        q_due.push_back(cyc + lat - 1);
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = q_addr[0] ^ KEY;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits (bounded) for the next popped head word; sampled mid-cycle.
  task automatic next_word(output logic [31:0] pc, output logic [31:0] w, output bit to);
    to = 1'b1;
    pc = '0;
    w  = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid && next_instr) begin
        pc = instr_pc;
        w  = instr;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    lat = 1; imem_gnt = 1'b1; next_instr = 1'b1; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 00000000", imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 00000000", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_instr_pc: got %h want 00000000", instr_pc); end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (instr_valid) break;
    end
    total++; if (n !== 3) begin bad++; $display("FAIL first_valid_latency: got %0d want 3", n); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL first_pc: got %h want 00000000", instr_pc); end
    total++; if (instr !== KEY) begin bad++; $display("FAIL first_instr: got %h want %h", instr, KEY); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    for (int i = 1; i < 12; i++) begin
      exp = 32'(4 * i);
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || instr_pc !== exp) begin bad++; $display("FAIL stream_pc[%0d]: got v=%b %h want v=1 %h", i, instr_valid, instr_pc, exp); end
      total++; if (instr !== (exp ^ KEY)) begin bad++; $display("FAIL stream_instr[%0d]: got %h want %h", i, instr, exp ^ KEY); end
      total++; if (imem_req !== 1'b1 || imem_addr !== exp + 32'd8) begin bad++; $display("FAIL stream_addr[%0d]: got req=%b %h want req=1 %h", i, imem_req, imem_addr, exp + 32'd8); end
    end
  endtask

  task automatic test_backpressure();
    int ng;
    logic [31:0] pc, w, exp;
    bit to;
    lat = 1; imem_gnt = 1'b1; next_instr = 1'b0;
    pulse_reset();
    ng = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) ng++;
    end
    total++; if (ng !== 4) begin bad++; $display("FAIL bp_grants: got %0d want 4", ng); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_stalled: got %b want 0", imem_req); end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got v=%b %h want v=1 00000000", instr_valid, instr_pc); end
    @(posedge clk); #1;
    next_instr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp = 32'(4 * i);
      next_word(pc, w, to);
      total++; if (to || pc !== exp) begin bad++; $display("FAIL bp_pc[%0d]: got %h want %h timeout=%0b", i, pc, exp, to); end
      total++; if (w !== (exp ^ KEY)) begin bad++; $display("FAIL bp_instr[%0d]: got %h want %h", i, w, exp ^ KEY); end
    end
  endtask

  task automatic test_redirect_drain();
    int nrv, nvalid;
    bit rose;
    logic [31:0] pc, w;
    bit to;
    lat = 3; imem_gnt = 1'b1; next_instr = 1'b1;
    pulse_reset();
    repeat (3) @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    nrv = 0; nvalid = 0; rose = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin rose = 1'b1; break; end
      if (imem_rvalid) nrv++;
      if (instr_valid) nvalid++;
    end
    total++; if (!rose) begin bad++; $display("FAIL drain_req_return: got req never re-asserted want re-assert"); end
    total++; if (nrv !== 2) begin bad++; $display("FAIL drain_rvalid_count: got %0d want 2", nrv); end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL drain_stale_visible: got %0d want 0", nvalid); end
    total++; if (imem_addr !== 32'h0000_0100) begin bad++; $display("FAIL drain_addr: got %h want 00000100", imem_addr); end
    next_word(pc, w, to);
    total++; if (to || pc !== 32'h0000_0100) begin bad++; $display("FAIL drain_first_pc: got %h want 00000100 timeout=%0b", pc, to); end
    total++; if (w !== (32'h0000_0100 ^ KEY)) begin bad++; $display("FAIL drain_first_instr: got %h want %h", w, 32'h0000_0100 ^ KEY); end
  endtask

  task automatic test_redirect_same_cycle();
    logic [31:0] pc, w;
    bit to;
    lat = 1; imem_gnt = 1'b1; next_instr = 1'b1;
    pulse_reset();
    repeat (4) @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    total++; if ({imem_req, imem_gnt, imem_rvalid} !== 3'b111) begin bad++; $display("FAIL same_cycle_setup: got %b want 111", {imem_req, imem_gnt, imem_rvalid}); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL same_cycle_flush_req: got %b want 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL same_cycle_dropped: got %b want 0", instr_valid); end
    total++; if (imem_rvalid !== 1'b1) begin bad++; $display("FAIL same_cycle_stale_resp: got %b want 1", imem_rvalid); end
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL same_cycle_restart: got req=%b %h want req=1 00000200", imem_req, imem_addr); end
    next_word(pc, w, to);
    total++; if (to || pc !== 32'h0000_0200) begin bad++; $display("FAIL same_cycle_first_pc: got %h want 00000200 timeout=%0b", pc, to); end
  endtask

  task automatic test_wrap();
    logic [31:0] pc, w, exp;
    bit to;
    logic [31:0] exp_tab [3];
    exp_tab[0] = 32'hFFFF_FFFC;
    exp_tab[1] = 32'h0000_0000;
    exp_tab[2] = 32'h0000_0004;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = exp_tab[i];
      next_word(pc, w, to);
      total++; if (to || pc !== exp) begin bad++; $display("FAIL wrap_pc[%0d]: got %h want %h timeout=%0b", i, pc, exp, to); end
      total++; if (w !== (exp ^ KEY)) begin bad++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, w, exp ^ KEY); end
    end
  endtask

  task automatic test_misaligned_redirect();
    logic [31:0] pc, w;
    bit to;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0303;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    next_word(pc, w, to);
    total++; if (to || pc !== 32'h0000_0300) begin bad++; $display("FAIL misaligned_pc: got %h want 00000300 timeout=%0b", pc, to); end
    total++; if (w !== (32'h0000_0300 ^ KEY)) begin bad++; $display("FAIL misaligned_instr: got %h want %h", w, 32'h0000_0300 ^ KEY); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] pc, w, exp;
    bit to;
    lat = 3; imem_gnt = 1'b1; next_instr = 1'b0;
    pulse_reset();
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL midrst_setup_valid: got %b want 1", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", instr_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL midrst_req: got %b want 0", imem_req); end
    lat = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    next_instr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = 32'(4 * i);
      next_word(pc, w, to);
      total++; if (to || pc !== exp) begin bad++; $display("FAIL midrst_pc[%0d]: got %h want %h timeout=%0b", i, pc, exp, to); end
      total++; if (w !== (exp ^ KEY)) begin bad++; $display("FAIL midrst_instr[%0d]: got %h want %h", i, w, exp ^ KEY); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_redirect_same_cycle();
    test_wrap();
    test_misaligned_redirect();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
